// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Constant-evaluable ceil(log2(v)).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set bit at or after a start index, wrapping
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     start,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  int             cand;
  logic [IDW-1:0] cand_idx;

  // Scan from farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(start) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDW-1:0];
      if (valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet-locked arbiter for a shared FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int IDW        = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int BW = clog2(MAX_BURST + 1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [BW-1:0]  beat_cnt;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           release_now;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_pick (
    .valid(req_valid),
    .start(rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == LOCK && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en  = req_valid[grant_id] & req_ready[grant_id];
  assign fifo_din    = (state == LOCK) ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy        = (state == LOCK);
  assign release_now = fifo_wr_en &
                       (req_last[grant_id] | (beat_cnt == BW'(MAX_BURST - 1)));

  // almost_full only holds off new grants; a locked packet runs until full.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found && !fifo_almost_full) state_nxt = LOCK;
      LOCK:    if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOCK) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (fifo_wr_en) begin
        if (release_now) begin
          beat_cnt <= '0;
          rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   fifo_din;
  logic            fifo_wr_en, fifo_full, fifo_almost_full;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_din        (fifo_din),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: locked flag, grantee, beats taken, round-robin start.
  bit m_lock;
  int m_gid, m_cnt, m_rr;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_lock && !fifo_full) r[m_gid] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_wr();
    return m_lock && !fifo_full && req_valid[m_gid];
  endfunction

  function automatic logic [DW-1:0] exp_din();
    return m_lock ? req_data[m_gid*DW +: DW] : '0;
  endfunction

  task automatic model_step();
    bit w;
    bit got_one;
    w = exp_wr();
    if (!rst_n) begin
      m_lock = 0; m_gid = 0; m_cnt = 0; m_rr = 0;
    end else if (!m_lock) begin
      if (req_valid != 0 && !fifo_almost_full) begin
        got_one = 0;
        for (int k = 0; k < N; k++) begin
          if (!got_one && req_valid[(m_rr + k) % N]) begin
            m_gid   = (m_rr + k) % N;
            got_one = 1;
          end
        end
        m_cnt  = 0;
        m_lock = 1;
      end
    end else if (w) begin
      if (req_last[m_gid] || m_cnt + 1 == MAXB) begin
        m_lock = 0;
        m_rr   = (m_gid + 1) % N;
      end else begin
        m_cnt++;
      end
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         q[N][$];
  logic [DW-1:0] sent[N][$];
  logic [DW-1:0] got[N][$];
  int            grants[$];
  bit            prev_busy;

  task automatic drive_q();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = q[i][0].d;
        req_last[i]          = q[i][0].l;
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit use_q);
    bit w;
    int g;
    @(negedge clk);
    chk("ready", req_ready, exp_ready());
    chk("wr_en", fifo_wr_en, exp_wr());
    chk("din", fifo_din, exp_din());
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_lock);
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    prev_busy = busy;
    w = exp_wr();
    g = m_gid;
    if (w) got[g].push_back(fifo_din);
    model_step();
    if (use_q && w && q[g].size() > 0) q[g].delete(0);
    @(posedge clk);
    #1;
    if (use_q) drive_q();
  endtask

  task automatic do_reset();
    rst_n = 0; req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 0; fifo_almost_full = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_lock = 0; m_gid = 0; m_cnt = 0; m_rr = 0;
    prev_busy = 0;
    grants.delete();
    for (int i = 0; i < N; i++) begin
      q[i].delete(); sent[i].delete(); got[i].delete();
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int tag);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = 8'(r * 64 + (tag * 16 + k) % 64);
      b.l = (k == len - 1);
      q[r].push_back(b);
      sent[r].push_back(b.d);
    end
  endtask

  task automatic run_until_empty(input int budget, output int used);
    bit empty;
    used = 0;
    empty = 0;
    while (!empty && used < budget) begin
      cycle(1);
      used++;
      empty = !m_lock;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
    end
  endtask

  task automatic check_sb(input string name);
    for (int i = 0; i < N; i++) begin
      chk({name, "_count"}, got[i].size(), sent[i].size());
      for (int j = 0; j < sent[i].size() && j < got[i].size(); j++)
        chk({name, "_data"}, got[i][j], sent[i][j]);
    end
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    chk({name, "_n"}, grants.size(), exp.size());
    for (int k = 0; k < exp.size() && k < grants.size(); k++)
      chk(name, grants[k], exp[k]);
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  v, l;
    logic          f, af;
    logic [N-1:0]  ready;
    logic          wr;
    logic [DW-1:0] din;
    logic [1:0]    gid;
    logic          bsy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic f, input logic af, input logic [3:0] ready,
                              input logic wr, input logic [7:0] din, input logic [1:0] gid,
                              input logic bsy);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.f = f; t.af = af;
    t.ready = ready; t.wr = wr; t.din = din; t.gid = gid; t.bsy = bsy;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int used;

    tbl.push_back(mk(0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 4'h1, 1, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h3, 4'h3, 0, 0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 4'h3, 4'h3, 0, 0, 4'h2, 1, 8'h22, 1, 1));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 1, 4'h0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 1, 4'h0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 4'h0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 1, 0, 4'h0, 0, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 1, 0, 4'h0, 0, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 1, 0, 4'h0, 0, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 1, 4'h1, 1, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h1, 0, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 0, 4'h1, 1, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 8'h00, 0, 0));

    rst_n = 0; req_valid = '1; req_last = '0; req_data = 32'h44332211;
    fifo_full = 0; fifo_almost_full = 0;
    @(posedge clk);
    #1;
    for (int r = 0; r < tbl.size(); r++) begin
      rst_n = tbl[r].rst; req_valid = tbl[r].v; req_last = tbl[r].l;
      fifo_full = tbl[r].f; fifo_almost_full = tbl[r].af;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("tbl%0d_wr_en", r), fifo_wr_en, tbl[r].wr);
      chk($sformatf("tbl%0d_din", r), fifo_din, tbl[r].din);
      chk($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].gid);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      @(posedge clk);
      #1;
    end

    // Continuous 2-beat packets from all requesters: 3 cycles per packet.
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 2, 0);
      push_pkt(r, 2, 1);
    end
    drive_q();
    run_until_empty(200, used);
    chk("rr_cycles", used, 24);
    check_grants("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});
    check_sb("rr_sb");

    // Locked packet under competition.
    do_reset();
    push_pkt(0, 3, 0);
    push_pkt(1, 1, 0);
    drive_q();
    run_until_empty(100, used);
    chk("lock_cycles", used, 6);
    check_grants("lock_order", '{0, 1});
    check_sb("lock_sb");

    // Forced release after MAX_BURST beats.
    do_reset();
    push_pkt(2, 10, 0);
    push_pkt(3, 2, 0);
    drive_q();
    run_until_empty(100, used);
    chk("burst_cycles", used, 16);
    check_grants("burst_order", '{2, 3, 2, 2});
    check_sb("burst_sb");

    // Reset during beat 2 of 4; requester 1 waiting.
    do_reset();
    push_pkt(0, 4, 0);
    push_pkt(1, 1, 0);
    drive_q();
    cycle(1);
    cycle(1);
    rst_n = 0;
    cycle(1);
    rst_n = 1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_grant_id", grant_id, 0);
    cycle(1);
    cycle(1);
    chk("rst_regrant_busy", busy, 1);
    chk("rst_regrant_grant_id", grant_id, 0);
    run_until_empty(100, used);
    chk("rst_drain_done", used < 100, 1);

    // Random stimulus against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n            = ($urandom_range(0, 99) != 0);
      req_valid        = N'($urandom);
      req_last         = N'($urandom);
      req_data         = $urandom;
      fifo_full        = ($urandom_range(0, 3) == 0);
      fifo_almost_full = ($urandom_range(0, 3) == 0);
      cycle(0);
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
